// File: rtl/dmac_pkg.sv
// Shared definitions for the dmac memory-to-memory DMA engine:
// register map, CTRL/STAT bit positions and FSM state encoding.
package dmac_pkg;

    localparam int WIDTH_CNT_DEF = 16;

    localparam logic [2:0] DMAC_SRC_H = 3'd0;
    localparam logic [2:0] DMAC_SRC_L = 3'd1;
    localparam logic [2:0] DMAC_DST_H = 3'd2;
    localparam logic [2:0] DMAC_DST_L = 3'd3;
    localparam logic [2:0] DMAC_CNT_H = 3'd4;
    localparam logic [2:0] DMAC_CNT_L = 3'd5;
    localparam logic [2:0] DMAC_CTRL  = 3'd6;
    localparam logic [2:0] DMAC_FILL  = 3'd7;

    localparam int CTRL_START     = 0;
    localparam int CTRL_FILL      = 1;
    localparam int CTRL_IEN       = 2;
    localparam int CTRL_SRC_FIXED = 3;
    localparam int CTRL_DST_FIXED = 4;
    localparam int CTRL_ABORT     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD_A,
        ST_RD_D,
        ST_WR,
        ST_FIN
    } dmac_state_e;

endpackage

// File: rtl/dmac_regs.sv
// CPU-facing register file of the dmac: control bits, fill byte, done flag,
// read-back mux and the write-protect that applies while a transfer runs.
module dmac_regs
    import dmac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ad_i,
    input  logic [7:0]  di_i,
    input  logic        rw_i,
    input  logic        cs_i,
    input  logic        busy_i,
    input  logic        set_done_i,
    input  logic [15:0] src_i,
    input  logic [15:0] dst_i,
    input  logic [15:0] cnt_i,
    output logic [7:0]  do_o,
    output logic [5:0]  ld_o,
    output logic        start_o,
    output logic        abort_o,
    output logic        fill_o,
    output logic        src_fixed_o,
    output logic        dst_fixed_o,
    output logic [7:0]  fill_byte_o,
    output logic        irq_o
);

    logic [4:0] ctrl_q, ctrl_d;
    logic [7:0] fill_q, fill_d;
    logic       done_q, done_d;
    logic       wr_en, ctrl_wr, stat_rd;

    // wr_en only covers idle writes; a busy CTRL write can still abort
    assign wr_en   = cs_i & ~rw_i & ~busy_i;
    assign ctrl_wr = cs_i & ~rw_i & (ad_i == DMAC_CTRL);
    assign stat_rd = cs_i & rw_i & (ad_i == DMAC_CTRL);
    assign start_o = ctrl_wr & ~busy_i & di_i[CTRL_START];
    assign abort_o = ctrl_wr & busy_i & di_i[CTRL_ABORT];

    always_comb begin
        ld_o = '0;
        for (int i = 0; i < 6; i++)
            ld_o[i] = wr_en & (ad_i == 3'(i));
    end

    always_comb begin
        ctrl_d = ctrl_q;
        fill_d = fill_q;
        done_d = done_q;
        if (wr_en && ad_i == DMAC_CTRL) ctrl_d = di_i[4:0];
        if (wr_en && ad_i == DMAC_FILL) fill_d = di_i;
        if (stat_rd || start_o)         done_d = 1'b0;
        // completion wins over a same-cycle STAT read
        if (set_done_i)                 done_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            fill_q <= '0;
            done_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            fill_q <= fill_d;
            done_q <= done_d;
        end
    end

    assign fill_o      = ctrl_q[CTRL_FILL];
    assign src_fixed_o = ctrl_q[CTRL_SRC_FIXED];
    assign dst_fixed_o = ctrl_q[CTRL_DST_FIXED];
    assign fill_byte_o = fill_q;
    assign irq_o       = done_q & ctrl_q[CTRL_IEN];

    always_comb begin
        case (ad_i)
            DMAC_SRC_H: do_o = src_i[15:8];
            DMAC_SRC_L: do_o = src_i[7:0];
            DMAC_DST_H: do_o = dst_i[15:8];
            DMAC_DST_L: do_o = dst_i[7:0];
            DMAC_CNT_H: do_o = cnt_i[15:8];
            DMAC_CNT_L: do_o = cnt_i[7:0];
            DMAC_CTRL:  do_o = {busy_i, done_q, 3'b000, ctrl_q[2:0]};
            DMAC_FILL:  do_o = fill_q;
            default:    do_o = '0;
        endcase
    end

endmodule

// File: rtl/dmac.sv
// dmac top: transfer FSM, address/count counters and the registered
// initiator bus (hold, MAD, MDO, mrw, mvma).
module dmac
    import dmac_pkg::*;
#(
    parameter int WIDTH_CNT = WIDTH_CNT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  AD,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    input  logic        rw,
    input  logic        cs,
    output logic        irq,
    output logic        hold,
    output logic [15:0] MAD,
    output logic [7:0]  MDO,
    input  logic [7:0]  MDI,
    output logic        mrw,
    output logic        mvma
);

    dmac_state_e          state_q, state_d;
    logic [15:0]          src_q, src_d, dst_q, dst_d;
    logic [WIDTH_CNT-1:0] cnt_q, cnt_d;
    logic [15:0]          cnt_w, cnt_rd;
    logic [7:0]           data_q, data_d;
    logic                 hold_q, hold_d, mvma_q, mvma_d, mrw_q, mrw_d;
    logic [15:0]          mad_q, mad_d;
    logic [7:0]           mdo_q, mdo_d;

    logic       busy, start, abort, fill_mode, src_fixed, dst_fixed;
    logic [5:0] ld;
    logic [7:0] fill_byte;

    assign busy   = (state_q != ST_IDLE);
    assign cnt_rd = 16'(cnt_q);

    dmac_regs u_regs (
        .clk         (clk),
        .rst         (rst),
        .ad_i        (AD),
        .di_i        (DI),
        .rw_i        (rw),
        .cs_i        (cs),
        .busy_i      (busy),
        .set_done_i  (state_q == ST_FIN),
        .src_i       (src_q),
        .dst_i       (dst_q),
        .cnt_i       (cnt_rd),
        .do_o        (DO),
        .ld_o        (ld),
        .start_o     (start),
        .abort_o     (abort),
        .fill_o      (fill_mode),
        .src_fixed_o (src_fixed),
        .dst_fixed_o (dst_fixed),
        .fill_byte_o (fill_byte),
        .irq_o       (irq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  state_d = fill_mode ? ST_WR : ST_RD_A;
            ST_RD_A: state_d = ST_RD_D;
            ST_RD_D: state_d = ST_WR;
            ST_WR: begin
                if (cnt_q == WIDTH_CNT'(1)) state_d = ST_FIN;
                else                        state_d = fill_mode ? ST_WR : ST_RD_A;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE && state_q != ST_FIN) state_d = ST_FIN;
    end

    // bus values are computed for the upcoming state so they leave flops
    always_comb begin
        hold_d = (state_d != ST_IDLE);
        mvma_d = 1'b0;
        mrw_d  = 1'b1;
        mad_d  = '0;
        mdo_d  = '0;
        case (state_d)
            ST_RD_A, ST_RD_D: begin
                mvma_d = 1'b1;
                mad_d  = src_d;
            end
            ST_WR: begin
                mvma_d = 1'b1;
                mrw_d  = 1'b0;
                mad_d  = dst_d;
                mdo_d  = fill_mode ? fill_byte : data_d;
            end
            default: ;
        endcase
    end

    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        cnt_w  = cnt_rd;
        data_d = data_q;
        if (ld[DMAC_SRC_H]) src_d[15:8] = DI;
        if (ld[DMAC_SRC_L]) src_d[7:0]  = DI;
        if (ld[DMAC_DST_H]) dst_d[15:8] = DI;
        if (ld[DMAC_DST_L]) dst_d[7:0]  = DI;
        if (ld[DMAC_CNT_H]) cnt_w[15:8] = DI;
        if (ld[DMAC_CNT_L]) cnt_w[7:0]  = DI;
        cnt_d = WIDTH_CNT'(cnt_w);
        if (state_q == ST_RD_D && !abort) data_d = MDI;
        // an aborted write cycle leaves the counters untouched
        if (state_q == ST_WR && !abort) begin
            if (!src_fixed) src_d = src_q + 16'd1;
            if (!dst_fixed) dst_d = dst_q + 16'd1;
            cnt_d = cnt_q - WIDTH_CNT'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            hold_q <= 1'b0;
            mvma_q <= 1'b0;
            mrw_q  <= 1'b1;
            mad_q  <= '0;
            mdo_q  <= '0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            hold_q <= hold_d;
            mvma_q <= mvma_d;
            mrw_q  <= mrw_d;
            mad_q  <= mad_d;
            mdo_q  <= mdo_d;
        end
    end

    assign hold = hold_q;
    assign mvma = mvma_q;
    assign mrw  = mrw_q;
    assign MAD  = mad_q;
    assign MDO  = mdo_q;

endmodule

// File: tb/tb_dmac.sv
// Self-checking bench for dmac: directed copy/fill/wrap/abort/reset cases
// plus randomized transfers checked against a byte-level transfer model.
module tb_dmac;

    logic        clk, rst, rw, cs;
    logic [2:0]  AD;
    logic [7:0]  DI, DO, MDO, MDI;
    logic        irq, hold, mrw, mvma;
    logic [15:0] MAD;

    logic [7:0]  mem  [0:65535];
    logic [7:0]  refm [0:65535];
    logic [15:0] wr_a[$], rd_a[$], ex_a[$];
    logic [7:0]  wr_d[$], ex_d[$];
    int          nchk, nerr, hold_cyc;

    dmac dut (
        .clk  (clk),
        .rst  (rst),
        .AD   (AD),
        .DI   (DI),
        .DO   (DO),
        .rw   (rw),
        .cs   (cs),
        .irq  (irq),
        .hold (hold),
        .MAD  (MAD),
        .MDO  (MDO),
        .MDI  (MDI),
        .mrw  (mrw),
        .mvma (mvma)
    );

    assign MDI = mem[MAD];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: sample the bus mid-cycle (memory model), return at posedge+1
    task automatic tick();
        @(negedge clk);
        if (hold) hold_cyc++;
        if (mvma && !mrw) begin
            mem[MAD] = MDO;
            wr_a.push_back(MAD);
            wr_d.push_back(MDO);
        end
        if (mvma && mrw) rd_a.push_back(MAD);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        tick();
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; rw = 1'b1; AD = a;
        #2 d = DO;
        tick();
        cs = 1'b0;
    endtask

    task automatic rd16(input logic [2:0] hi, output logic [15:0] w);
        logic [7:0] h, l;
        rd(hi, h);
        rd(hi + 3'd1, l);
        w = {h, l};
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                        input logic [7:0] f);
        wr(3'd0, s[15:8]); wr(3'd1, s[7:0]);
        wr(3'd2, d[15:8]); wr(3'd3, d[7:0]);
        wr(3'd4, n[15:8]); wr(3'd5, n[7:0]);
        wr(3'd7, f);
    endtask

    task automatic go(input logic [7:0] ctrl, output int hc);
        int h0;
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        h0 = hold_cyc;
        wr(3'd6, ctrl);
        for (int i = 0; i < 2000; i++) begin
            if (!hold) break;
            tick();
        end
        chk("timeout_hold", {31'd0, hold}, 32'd0);
        hc = hold_cyc - h0;
    endtask

    initial begin
        logic [7:0]  v;
        logic [15:0] w, s, d, sa, da;
        int          hc, n, bad, lo;
        logic        fl, ien, sfx, dfx;
        logic [7:0]  fb, ctrl;

        nchk = 0; nerr = 0; hold_cyc = 0;
        rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = '0; DI = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);

        // reset state
        #2;
        chk("rst_hold", {31'd0, hold}, 0);
        chk("rst_irq",  {31'd0, irq}, 0);
        chk("rst_mvma", {31'd0, mvma}, 0);
        chk("rst_mrw",  {31'd0, mrw}, 1);
        chk("rst_mad",  {16'd0, MAD}, 0);
        chk("rst_mdo",  {24'd0, MDO}, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            AD = 3'(i); #1;
            if (DO !== 8'h00) bad++;
        end
        chk("rst_regs", bad, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // copy of four bytes
        mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
        prog(16'h0100, 16'h0200, 16'd4, 8'h00);
        go(8'h01, hc);
        chk("copy_hold_cycles", hc, 14);
        chk("copy_nwr", wr_a.size(), 4);
        bad = 0;
        for (int i = 0; i < wr_a.size() && i < 4; i++) begin
            if (wr_a[i] !== 16'h0200 + 16'(i)) bad++;
            if (wr_d[i] !== 8'(8'h11 * (i + 1))) bad++;
        end
        chk("copy_writes", bad, 0);
        rd16(3'd0, w); chk("copy_src", {16'd0, w}, 32'h0104);
        rd16(3'd2, w); chk("copy_dst", {16'd0, w}, 32'h0204);
        rd16(3'd4, w); chk("copy_cnt", {16'd0, w}, 32'h0000);
        rd(3'd6, v);   chk("copy_stat", {24'd0, v}, 32'h41);
        rd(3'd6, v);   chk("copy_stat_clr", {24'd0, v}, 32'h01);

        // fill with interrupt
        prog(16'h0104, 16'hE000, 16'd3, 8'hA5);
        go(8'h07, hc);
        chk("fill_hold_cycles", hc, 5);
        bad = (wr_a.size() == 3) ? 0 : 1;
        for (int i = 0; i < wr_a.size() && i < 3; i++) begin
            if (wr_a[i] !== 16'hE000 + 16'(i)) bad++;
            if (wr_d[i] !== 8'hA5) bad++;
        end
        chk("fill_writes", bad, 0);
        chk("fill_irq", {31'd0, irq}, 1);
        rd(3'd6, v);
        chk("fill_stat", {24'd0, v}, 32'h47);
        chk("fill_irq_clr", {31'd0, irq}, 0);

        // fixed source, destination wrapping through $FFFF
        mem[16'hE6B0] = 8'h5A;
        prog(16'hE6B0, 16'hFFFE, 16'd3, 8'h00);
        go(8'h09, hc);
        chk("wrap_nrd", rd_a.size(), 6);
        bad = 0;
        foreach (rd_a[i]) if (rd_a[i] !== 16'hE6B0) bad++;
        chk("wrap_rd_addr", bad, 0);
        bad = (wr_a.size() == 3) ? 0 : 1;
        for (int i = 0; i < wr_a.size() && i < 3; i++) begin
            if (wr_a[i] !== 16'hFFFE + 16'(i)) bad++;
            if (wr_d[i] !== 8'h5A) bad++;
        end
        chk("wrap_writes", bad, 0);
        rd16(3'd0, w); chk("wrap_src", {16'd0, w}, 32'hE6B0);
        rd16(3'd2, w); chk("wrap_dst", {16'd0, w}, 32'h0001);
        rd(3'd6, v);

        // randomized transfers against a byte-by-byte model
        for (int t = 0; t < 6; t++) begin
            s = 16'($urandom); d = 16'($urandom); n = $urandom_range(1, 12);
            fl = 1'($urandom_range(0, 1)); ien = 1'($urandom_range(0, 1));
            sfx = 1'($urandom_range(0, 1)); dfx = 1'($urandom_range(0, 1));
            fb = 8'($urandom);
            ctrl = {3'b000, dfx, sfx, ien, fl, 1'b1};
            refm = mem;
            ex_a.delete(); ex_d.delete();
            for (int i = 0; i < n; i++) begin
                sa = s + (sfx ? 16'd0 : 16'(i));
                da = d + (dfx ? 16'd0 : 16'(i));
                refm[da] = fl ? fb : refm[sa];
                ex_a.push_back(da);
                ex_d.push_back(refm[da]);
            end
            prog(s, d, 16'(n), fb);
            go(ctrl, hc);
            chk("rnd_hold_cycles", hc, fl ? n + 2 : 3 * n + 2);
            bad = (wr_a.size() == n) ? 0 : 1;
            for (int i = 0; i < wr_a.size() && i < n; i++)
                if (wr_a[i] !== ex_a[i] || wr_d[i] !== ex_d[i]) bad++;
            chk("rnd_writes", bad, 0);
            rd16(3'd0, w); chk("rnd_src", {16'd0, w}, {16'd0, s + (sfx ? 16'd0 : 16'(n))});
            rd16(3'd2, w); chk("rnd_dst", {16'd0, w}, {16'd0, d + (dfx ? 16'd0 : 16'(n))});
            rd16(3'd4, w); chk("rnd_cnt", {16'd0, w}, 0);
            chk("rnd_irq", {31'd0, irq}, {31'd0, ien});
            rd(3'd6, v);   chk("rnd_stat", {24'd0, v}, {24'd0, 8'h40 | {5'd0, ien, fl, 1'b1}});
        end

        // abort mid-copy
        prog(16'h1000, 16'h2000, 16'd100, 8'h00);
        wr_a.delete(); wr_d.delete();
        wr(3'd6, 8'h01);
        for (int i = 0; i < 10; i++) tick();
        wr(3'd6, 8'h80);
        chk("abort_fin_hold", {31'd0, hold}, 1);
        tick();
        chk("abort_hold_drop", {31'd0, hold}, 0);
        rd16(3'd4, w);
        chk("abort_cnt_range", {31'd0, (w >= 16'd96 && w <= 16'd98)}, 1);
        lo = wr_a.size() - (100 - int'(w));
        chk("abort_wr_consistent", {31'd0, (lo == 0 || lo == 1)}, 1);
        rd(3'd6, v);
        chk("abort_stat", {24'd0, v}, 32'h41);

        // write-protect while busy, then asynchronous reset mid-write
        prog(16'h0300, 16'h0400, 16'd8, 8'h00);
        wr(3'd6, 8'h01);
        tick(); tick();
        wr(3'd0, 8'h55);
        rd(3'd0, v);
        chk("busy_src_h_protect", {24'd0, v}, 32'h03);
        bad = 1;
        for (int i = 0; i < 20; i++) begin
            if (mvma && !mrw) begin bad = 0; break; end
            tick();
        end
        chk("reset_found_wr", bad, 0);
        rst = 1'b1;
        #1;
        chk("reset_hold_async", {31'd0, hold}, 0);
        chk("reset_mvma_async", {31'd0, mvma}, 0);
        chk("reset_mad_async", {16'd0, MAD}, 0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            if (v !== 8'h00) bad++;
        end
        chk("reset_regs_zero", bad, 0);
        chk("reset_irq", {31'd0, irq}, 0);
        chk("reset_idle_hold", {31'd0, hold}, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
